data_collector: RTL

DATA_COLLECTOR -- requirements
Module: data_collector

---
 rtl/data_collector.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/data_collector.sv
`default_nettype none
// ============================================================================
// Module   : data_collector
// Brief    : Reassembles a 64-bit seg / 16-bit led word from 16 indexed 5-bit
//            chunks delivered on a slow, asynchronous transfer strobe.
// Revision : 1.0
// ============================================================================
module data_collector #(
    parameter int          SAMPLE_DLY = 4,
    parameter logic [31:0] TIMEOUT    = 32'd10_000_000
) (
    input  logic        clk_100mhz,
    input  logic        rst,
    input  logic        clk,
    input  logic [4:0]  in_data,
    input  logic [3:0]  in_idx,
    output logic [63:0] seg_out,
    output logic [15:0] led_out,
    output logic        frame_valid,
    output logic        seq_err,
    output logic [15:0] frame_cnt
);

    localparam logic [7:0]  c_DLY     = 8'(SAMPLE_DLY);
    localparam logic [31:0] c_TO_LAST = TIMEOUT - 32'd1;

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_COLLECT = 2'd1;
    localparam logic [1:0] c_DONE    = 2'd2;

    logic        r_sync1, r_sync2, r_hist;
    logic [7:0]  r_dly;
    logic [31:0] r_to;
    logic [1:0]  r_state;
    logic [3:0]  r_exp;
    logic [63:0] r_seg_sh, r_seg;
    logic [15:0] r_led_sh, r_led;
    logic        r_frame_valid, r_seq_err;
    logic [15:0] r_frame_cnt;

    logic        w_evt, w_fire, w_timeout, w_match;
    logic [3:0]  w_pos;
    logic [63:0] w_seg_first;
    logic [15:0] w_led_first;

    assign w_evt       = r_sync2 & ~r_hist;
    assign w_fire      = ~w_evt & (r_dly == 8'd1);
    assign w_timeout   = (r_state == c_COLLECT) & ~w_fire & ~w_evt & (r_to == c_TO_LAST);
    assign w_match     = (in_idx == r_exp);
    // Chunk j lands at nibble/bit position 15-j; index 0 carries chunk 15.
    assign w_pos       = ~(in_idx - 4'd1);
    assign w_seg_first = {in_data[4:1], 60'd0};
    assign w_led_first = {in_data[0], 15'd0};

    always_ff @(posedge clk_100mhz) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_hist  <= 1'b0;
            r_dly   <= 8'd0;
            r_to    <= 32'd0;
        end else begin
            r_sync1 <= clk;
            r_sync2 <= r_sync1;
            r_hist  <= r_sync2;
            if (w_evt)
                r_dly <= c_DLY;
            else if (r_dly != 8'd0)
                r_dly <= r_dly - 8'd1;
            // Saturating idle counter; only acted upon while collecting.
            if (w_evt)
                r_to <= 32'd0;
            else if (r_to != c_TO_LAST)
                r_to <= r_to + 32'd1;
        end
    end

    always_ff @(posedge clk_100mhz) begin
        if (rst) begin
            r_state       <= c_IDLE;
            r_exp         <= 4'd0;
            r_seg_sh      <= 64'd0;
            r_led_sh      <= 16'd0;
            r_seg         <= 64'd0;
            r_led         <= 16'd0;
            r_frame_valid <= 1'b0;
            r_seq_err     <= 1'b0;
            r_frame_cnt   <= 16'd0;
        end else begin
            r_frame_valid <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_fire && in_idx == 4'd1) begin
                        r_seg_sh <= w_seg_first;
                        r_led_sh <= w_led_first;
                        r_exp    <= 4'd2;
                        r_state  <= c_COLLECT;
                    end
                end
                c_COLLECT: begin
                    if (w_fire) begin
                        if (w_match) begin
                            r_seg_sh[{w_pos, 2'b00} +: 4] <= in_data[4:1];
                            r_led_sh[w_pos]               <= in_data[0];
                            r_exp                         <= r_exp + 4'd1;
                            if (in_idx == 4'd0)
                                r_state <= c_DONE;
                        end else begin
                            r_seq_err <= 1'b1;
                            if (in_idx == 4'd1) begin
                                r_seg_sh <= w_seg_first;
                                r_led_sh <= w_led_first;
                                r_exp    <= 4'd2;
                            end else begin
                                r_seg_sh <= 64'd0;
                                r_led_sh <= 16'd0;
                                r_state  <= c_IDLE;
                            end
                        end
                    end else if (w_timeout) begin
                        r_seq_err <= 1'b1;
                        r_seg_sh  <= 64'd0;
                        r_led_sh  <= 16'd0;
                        r_state   <= c_IDLE;
                    end
                end
                c_DONE: begin
                    r_seg         <= r_seg_sh;
                    r_led         <= r_led_sh;
                    r_frame_valid <= 1'b1;
                    r_frame_cnt   <= r_frame_cnt + 16'd1;
                    r_seq_err     <= 1'b0;
                    r_state       <= c_IDLE;
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign seg_out     = r_seg;
    assign led_out     = r_led;
    assign frame_valid = r_frame_valid;
    assign seq_err     = r_seq_err;
    assign frame_cnt   = r_frame_cnt;

endmodule
`default_nettype wire
